// File: rtl/ysyx_23060025_icache_burst.sv
// rtl/ysyx_23060025_icache_burst.sv - direct-mapped instruction cache, whole-line INCR burst refill
// Optional hit/miss counters: define YSYX_23060025_ICACHE_PERF_EN.
module ysyx_23060025_icache_burst #(
  parameter int ADDR_WIDTH            = 32,
  parameter int DATA_WIDTH            = 32,
  parameter int CACHE_LINE_ADDR_W     = 4,
  parameter int CACHE_LINE_OFF_ADDR_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] in_paddr,
  input  logic                  in_psel,
  input  logic                  in_flush,
  output logic                  in_pready,
  output logic [DATA_WIDTH-1:0] in_prdata,
  output logic [ADDR_WIDTH-1:0] out_araddr,
  output logic                  out_arvalid,
  input  logic                  out_arready,
  output logic [7:0]            out_arlen,
  output logic [2:0]            out_arsize,
  output logic [1:0]            out_arburst,
  input  logic                  out_rvalid,
  input  logic [DATA_WIDTH-1:0] out_rdata,
  input  logic                  out_rlast,
  output logic                  out_rready
`ifdef YSYX_23060025_ICACHE_PERF_EN
  ,
  output logic [31:0]           perf_hit_cnt,
  output logic [31:0]           perf_miss_cnt
`endif
);

  localparam int LINES  = 1 << CACHE_LINE_ADDR_W;
  localparam int WORD_W = CACHE_LINE_OFF_ADDR_W - 2;
  localparam int WORDS  = 1 << WORD_W;
  localparam int BCW    = (WORD_W > 0) ? WORD_W : 1;
  localparam int TAG_W  = ADDR_WIDTH - CACHE_LINE_ADDR_W - CACHE_LINE_OFF_ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_AR, S_R, S_PASS} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [DATA_WIDTH-1:0]     r_data [LINES][WORDS];
  logic [TAG_W-1:0]          r_tag  [LINES];
  logic [LINES-1:0]          r_valid;
  logic                      r_flush_pend;
  logic [BCW-1:0]            r_beat;

  logic [TAG_W-1:0]             w_tag;
  logic [CACHE_LINE_ADDR_W-1:0] w_idx;
  logic [BCW-1:0]               w_off;
  logic [BCW-1:0]               w_beat_inc;
  logic                         w_hit;
  logic                         w_r_fire;

  assign w_tag      = in_paddr[ADDR_WIDTH-1 -: TAG_W];
  assign w_idx      = in_paddr[CACHE_LINE_OFF_ADDR_W +: CACHE_LINE_ADDR_W];
  assign w_off      = BCW'((in_paddr >> 2) & ADDR_WIDTH'(WORDS - 1));
  assign w_beat_inc = (WORD_W == 0) ? '0 : r_beat + BCW'(1);
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_r_fire   = (r_state == S_R) && out_rvalid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
      r_beat       <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_AR && out_arready) r_beat <= '0;
      if (w_r_fire) begin
        r_beat <= w_beat_inc;
        if (out_rlast) r_valid[w_idx] <= 1'b1;
      end
      // A flush during a transaction is deferred so the in-flight fetch still returns data.
      if (r_state == S_IDLE && in_flush) r_valid <= '0;
      else if (in_flush) r_flush_pend <= 1'b1;
      if (r_state == S_PASS && (r_flush_pend || in_flush)) begin
        r_valid      <= '0;
        r_flush_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_r_fire) begin
      r_data[w_idx][r_beat] <= out_rdata;
      if (out_rlast) r_tag[w_idx] <= w_tag;
    end
  end

`ifdef YSYX_23060025_ICACHE_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (r_state == S_CHECK) begin
      if (w_hit) perf_hit_cnt <= perf_hit_cnt + 32'd1;
      else perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    w_next      = r_state;
    in_pready   = 1'b0;
    in_prdata   = '0;
    out_araddr  = '0;
    out_arvalid = 1'b0;
    out_arlen   = '0;
    out_arsize  = '0;
    out_arburst = '0;
    out_rready  = 1'b0;
    case (r_state)
      S_IDLE:  if (in_psel) w_next = S_CHECK;
      S_CHECK: w_next = w_hit ? S_PASS : S_AR;
      S_AR: begin
        out_arvalid = 1'b1;
        out_araddr  = {w_tag, w_idx, {CACHE_LINE_OFF_ADDR_W{1'b0}}};
        out_arlen   = 8'(WORDS - 1);
        out_arsize  = 3'b010;
        out_arburst = 2'b01;
        if (out_arready) w_next = S_R;
      end
      S_R: begin
        out_rready = 1'b1;
        if (out_rvalid && out_rlast) w_next = S_PASS;
      end
      S_PASS: begin
        // Always served from the array after the fill; no critical-word bypass.
        in_pready = 1'b1;
        in_prdata = r_data[w_idx][w_off];
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_icache_burst.sv
// tb/tb_ysyx_23060025_icache_burst.sv - directed bench with cycle-timeline model of the icache
module tb_ysyx_23060025_icache_burst;
  localparam int WORDS = 4;

  logic        clock, reset, in_psel, in_flush, in_pready;
  logic        out_arvalid, out_arready, out_rvalid, out_rlast, out_rready;
  logic [31:0] in_paddr, in_prdata, out_araddr, out_rdata;
  logic [7:0]  out_arlen;
  logic [2:0]  out_arsize;
  logic [1:0]  out_arburst;
`ifdef YSYX_23060025_ICACHE_PERF_EN
  logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

  ysyx_23060025_icache_burst dut (
    .clock(clock), .reset(reset), .in_paddr(in_paddr), .in_psel(in_psel), .in_flush(in_flush),
    .in_pready(in_pready), .in_prdata(in_prdata), .out_araddr(out_araddr),
    .out_arvalid(out_arvalid), .out_arready(out_arready), .out_arlen(out_arlen),
    .out_arsize(out_arsize), .out_arburst(out_arburst), .out_rvalid(out_rvalid),
    .out_rdata(out_rdata), .out_rlast(out_rlast), .out_rready(out_rready)
`ifdef YSYX_23060025_ICACHE_PERF_EN
    , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          skip = 1'b1;
  int          e_t0 = 1000000;
  int          e_tar = 0, e_tlast = 0, e_tpass = -1;
  bit          e_hit = 1'b0;
  logic [31:0] e_addr = '0;
  logic [31:0] last_prdata = '0, last_araddr = '0;
  bit          m_valid [16];
  logic [23:0] m_tag [16];
  int          m_hits = 0, m_misses = 0;

  function automatic logic [31:0] dram(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Expected outputs derive from the request timeline: hit -> data at t0+2;
  // miss -> AR from t0+2 to the arready cycle, R until the rlast beat, data one cycle later.
  always @(negedge clock) begin
    bit act, ev_arv, ev_rr, ev_pr;
    if (!skip) begin
      act    = (cyc >= e_t0) && (cyc <= e_tpass);
      ev_arv = act && !e_hit && (cyc >= e_t0 + 2) && (cyc <= e_tar);
      ev_rr  = act && !e_hit && (cyc > e_tar) && (cyc <= e_tlast);
      ev_pr  = act && (cyc == e_tpass);
      chk("arvalid", 32'(out_arvalid), 32'(ev_arv));
      chk("rready", 32'(out_rready), 32'(ev_rr));
      chk("pready", 32'(in_pready), 32'(ev_pr));
      if (ev_arv) begin
        chk("araddr", out_araddr, {e_addr[31:4], 4'b0});
        chk("arlen", 32'(out_arlen), WORDS - 1);
        chk("arsize", 32'(out_arsize), 32'd2);
        chk("arburst", 32'(out_arburst), 32'd1);
      end
      if (ev_pr) chk("prdata", in_prdata, dram(e_addr));
      if (out_arvalid) last_araddr = out_araddr;
      if (in_pready) last_prdata = in_prdata;
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // fl: cycle offset of an in_flush pulse (-1 none); rst_beats: assert reset after that many beats.
  task automatic fetch(input logic [31:0] a, input int d, input int g, input int fl,
                       input int rst_beats, input bit psel_mid);
    int n, tot, j, bi, idx;
    bit hit;
    logic [23:0] tg;
    idx = int'(a[7:4]);
    tg  = a[31:8];
    n   = cyc;
    if (fl == 0) clear_model();
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (hit) m_hits++;
    else m_misses++;
    e_hit   = hit;
    e_addr  = a;
    e_tar   = n + 2 + d;
    e_tlast = e_tar + WORDS + g;
    e_tpass = hit ? n + 2 : e_tlast + 1;
    e_t0    = n;
    tot     = e_tpass - n;
    in_paddr = a;
    for (int k = 0; k <= tot; k++) begin
      int c;
      c = n + k;
      in_psel     = (k == 0) || (psel_mid && !hit && c == e_tar + 1);
      in_flush    = (fl >= 0) && (k == fl);
      out_arready = !hit && (c == e_tar);
      out_rvalid  = 1'b0;
      out_rlast   = 1'b0;
      out_rdata   = '0;
      if (!hit && c > e_tar && c <= e_tlast) begin
        j = c - e_tar - 1;
        if (!(g != 0 && j == 1)) begin
          bi = (g != 0 && j > 1) ? j - 1 : j;
          out_rvalid = 1'b1;
          out_rdata  = dram({a[31:4], 4'b0} + 32'(4 * bi));
          out_rlast  = (bi == WORDS - 1);
        end
      end
      if (rst_beats > 0 && !hit && c == e_tar + 1 + rst_beats) begin
        reset = 1'b1;
        out_rvalid = 1'b0;
        skip = 1'b1;
        e_t0 = 1000000;
        @(posedge clock); #1;
        reset = 1'b0; in_psel = 1'b0; in_flush = 1'b0;
        skip = 1'b0;
        chk("rst_pready", 32'(in_pready), 32'd0);
        chk("rst_prdata", in_prdata, 32'd0);
        chk("rst_arvalid", 32'(out_arvalid), 32'd0);
        chk("rst_araddr", out_araddr, 32'd0);
        chk("rst_arlen", 32'(out_arlen), 32'd0);
        chk("rst_arburst", 32'(out_arburst), 32'd0);
        chk("rst_rready", 32'(out_rready), 32'd0);
        clear_model();
        m_hits = 0; m_misses = 0;
`ifdef YSYX_23060025_ICACHE_PERF_EN
        chk("rst_perf_hit", perf_hit_cnt, 32'd0);
        chk("rst_perf_miss", perf_miss_cnt, 32'd0);
`endif
        @(posedge clock); #1;
        return;
      end
      @(posedge clock); #1;
    end
    in_psel = 1'b0; in_flush = 1'b0; out_arready = 1'b0; out_rvalid = 1'b0; out_rlast = 1'b0;
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    if (fl > 0) clear_model();
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; in_psel = 1'b0; in_flush = 1'b0; in_paddr = '0;
    out_arready = 1'b0; out_rvalid = 1'b0; out_rdata = '0; out_rlast = 1'b0;
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    skip  = 1'b0;
    chk("reset_pready", 32'(in_pready), 32'd0);
    chk("reset_arvalid", 32'(out_arvalid), 32'd0);
    chk("reset_rready", 32'(out_rready), 32'd0);
    chk("reset_araddr", out_araddr, 32'd0);
    @(posedge clock); #1;

    fetch(32'h8000_0010, 0, 0, -1, 0, 1'b0);
    chk("t1_araddr", last_araddr, 32'h8000_0010);
    chk("t1_data", last_prdata, 32'h7FFF_FFEF);

    last_araddr = '0;
    fetch(32'h8000_0014, 0, 0, -1, 0, 1'b0);
    chk("t2_hit_no_ar", last_araddr, 32'h0);
    chk("t2_data", last_prdata, 32'h7FFF_FFEB);
`ifdef YSYX_23060025_ICACHE_PERF_EN
    chk("t2_perf_hit", perf_hit_cnt, 32'd1);
`endif

    fetch(32'h8000_0110, 0, 0, -1, 0, 1'b0);
    chk("t3_conflict_data", last_prdata, 32'h7FFF_FEEF);
    fetch(32'h8000_0010, 0, 0, -1, 0, 1'b0);
`ifdef YSYX_23060025_ICACHE_PERF_EN
    chk("t3_perf_miss", perf_miss_cnt, 32'd3);
`endif

    fetch(32'h8000_0030, 5, 1, -1, 0, 1'b1);
    chk("t4_data", last_prdata, 32'h7FFF_FFCF);

    fetch(32'h8000_0040, 0, 0, 3, 0, 1'b0);
    last_araddr = '0;
    fetch(32'h8000_0040, 0, 0, -1, 0, 1'b0);
    chk("t5_refetch_miss", last_araddr, 32'h8000_0040);

    last_araddr = '0;
    fetch(32'h8000_0040, 0, 0, 0, 0, 1'b0);
    chk("idle_flush_miss", last_araddr, 32'h8000_0040);
    fetch(32'h8000_0044, 0, 0, 1, 0, 1'b0);
    fetch(32'h8000_0048, 0, 0, -1, 0, 1'b0);

    fetch(32'h8000_0050, 0, 0, -1, 2, 1'b0);
    last_araddr = '0;
    fetch(32'h8000_0050, 0, 0, -1, 0, 1'b0);
    chk("t6_refetch_miss", last_araddr, 32'h8000_0050);
`ifdef YSYX_23060025_ICACHE_PERF_EN
    chk("perf_hit_final", perf_hit_cnt, 32'(m_hits));
    chk("perf_miss_final", perf_miss_cnt, 32'(m_misses));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
